// File: rtl/bram_stream_reader_if.sv
// Bundle of the burst-request, BRAM read-port and output-stream signals of
// bram_stream_reader. master is the reader side, slave is the side driving
// requests, returning BRAM data and consuming the stream.
interface bram_stream_reader_if #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
);
  // burst request / status
  logic                      start;
  logic [RAM_ADDR_WIDTH-1:0] start_addr;
  logic [RAM_ADDR_WIDTH:0]   length;
  logic                      busy;
  logic                      done;
  // BRAM read port (write enable tied low externally)
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [RAM_DATA_WIDTH-1:0] ram_data;
  // output stream
  logic [RAM_DATA_WIDTH-1:0] m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;

  modport master (
    input  start, start_addr, length, ram_data, m_ready,
    output busy, done, ram_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_addr, length, ram_data, m_ready,
    input  busy, done, ram_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader: issues `length` sequential BRAM reads starting at start_addr
// (address wraps), tracks the 1-cycle-latency reads through a 2-stage valid
// pipeline and streams the data out through a 3-entry FIFO. Reads are only
// issued when the FIFO plus everything in flight is guaranteed to fit, so
// backpressure never drops or duplicates a word.
module bram_stream_reader #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_stream_reader_if.master bus
);

  localparam int STAGES = 2;  // issue -> BRAM register -> FIFO write
  localparam int DEPTH  = 3;

  localparam logic [RAM_ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  typedef struct packed {
    logic                      last;
    logic [RAM_DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                    state, state_nx;
  logic [RAM_ADDR_WIDTH:0]   remain;      // reads still to be issued
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [STAGES-1:0]         vld_pipe;    // in-flight read tracking
  logic [STAGES-1:0]         last_pipe;   // marks the final read of a burst
  beat_t                     fifo [DEPTH];
  logic [1:0]                wr_ptr, rd_ptr, fifo_cnt;

  logic       accept, run_issue, issue, issue_last, push, pop, room;
  logic [2:0] inflight, occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue gating: a read may start only if its data is guaranteed a FIFO slot
  always_comb begin
    accept     = (state == IDLE) && bus.start;
    pop        = bus.m_valid && bus.m_ready;
    push       = vld_pipe[STAGES-1];
    inflight   = 3'(vld_pipe[0]) + 3'(vld_pipe[1]);
    occupancy  = 3'(fifo_cnt) + inflight;
    room       = occupancy < (3'(DEPTH) + 3'(pop));
    run_issue  = (state == RUN) && (remain != '0) && room;
    issue      = (accept && (bus.length != '0)) || run_issue;
    issue_last = accept ? (bus.length == LEN_ONE) : (remain == LEN_ONE);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.length == '0) ? FINISH : RUN;
      RUN:     if (pop && bus.m_last) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Read address and remaining-word counter; address holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      remain <= '0;
    end else if (accept) begin
      if (bus.length != '0) begin
        addr_q <= bus.start_addr;
        remain <= bus.length - LEN_ONE;
      end else begin
        remain <= '0;
      end
    end else if (run_issue) begin
      addr_q <= addr_q + ADDR_ONE;
      remain <= remain - LEN_ONE;
    end
  end

  // In-flight pipeline: stage 1 = address registered, stage 2 = data on ram_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-2:0], issue};
      last_pipe <= {last_pipe[STAGES-2:0], issue && issue_last};
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{last: last_pipe[STAGES-1], data: bus.ram_data};
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs all come from registers; m_valid never looks at m_ready
  assign bus.ram_addr = addr_q;
  assign bus.m_valid  = (fifo_cnt != '0);
  assign bus.m_data   = fifo[rd_ptr].data;
  assign bus.m_last   = fifo[rd_ptr].last && bus.m_valid;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);

  // The issue gating must make a full FIFO with a push and no pop impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == 2'(DEPTH)));

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter RAM_DATA_WIDTH, default 8, SHALL set the width of the BRAM read data and the stream data.
REQ-002 Parameter RAM_ADDR_WIDTH, default 4, SHALL set the BRAM address width; the address space is 2**RAM_ADDR_WIDTH words.
REQ-003 clk, input, 1: the single clock; all logic SHALL be rising-edge clocked on clk.
REQ-004 rst, input, 1: asynchronous, active-high reset.
REQ-005 start, input, 1: single-cycle request to begin a burst read; SHALL be sampled only in IDLE.
REQ-006 start_addr, input, RAM_ADDR_WIDTH: first BRAM word address of the burst.
REQ-007 length, input, RAM_ADDR_WIDTH+1: number of words in the burst; legal range is 0..2**RAM_ADDR_WIDTH.
REQ-008 busy, output, 1: high from the edge that accepts start until done is asserted.
REQ-009 done, output, 1: one-cycle pulse marking burst completion.
REQ-010 ram_addr, output, RAM_ADDR_WIDTH: registered address to the BRAM port; the write enable of that BRAM port is tied low externally.
REQ-011 ram_data, input, RAM_DATA_WIDTH: BRAM registered read data; it reflects the ram_addr presented on the previous edge (1-cycle read latency, no enable).
REQ-012 m_data, output, RAM_DATA_WIDTH: stream data.
REQ-013 m_valid, output, 1: stream valid.
REQ-014 m_ready, input, 1: stream ready.
REQ-015 m_last, output, 1: high with the final beat of a burst.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and FINISH.
- IDLE -> RUN on start with length != 0.
- IDLE -> FINISH on start with length == 0.
- RUN -> FINISH when the last beat handshakes (m_valid & m_ready & m_last).
- FINISH -> IDLE unconditionally after one cycle.
REQ-017 done SHALL be high exactly during the FINISH cycle; busy SHALL be high in RUN and FINISH.
REQ-018 start asserted while busy SHALL be ignored, with no effect on the current burst.
REQ-019 The read issue sequence SHALL be as follows.
- On each issue, ram_addr is loaded with the next address.
- The first issue is start_addr, on the edge that accepts start.
- Subsequent issues increment by 1 modulo 2**RAM_ADDR_WIDTH (wrap from all-ones to 0).
- Exactly length reads are issued per burst.
REQ-020 A 2-stage in-flight valid pipeline SHALL track issued reads; ram_data SHALL be written into the output FIFO on the edge after the corresponding read is registered by the BRAM.
REQ-021 The output FIFO SHALL be 3 entries deep and present its head on m_data/m_valid.
REQ-022 A new read SHALL be issued in a cycle only if all of the following hold:
- words remain to be issued;
- fifo_count + inflight_count - pop < 3, where pop = m_valid & m_ready in that cycle.
REQ-023 The FIFO SHALL never overflow and no read data SHALL be dropped or duplicated under any m_ready pattern.
REQ-024 m_valid SHALL NOT depend combinationally on m_ready; m_data and m_last SHALL be held stable while m_valid & !m_ready.
REQ-025 With m_ready held high, the first beat SHALL appear with m_valid high 2 cycles after the start edge, and throughput SHALL be 1 beat per cycle.
REQ-026 m_last SHALL be high only on beat number length of the burst.
REQ-027 ram_addr SHALL hold its last value when no read is issued.
REQ-028 A burst of length 2**RAM_ADDR_WIDTH SHALL read every address exactly once, starting at start_addr.

Reset
REQ-029 While rst is high, and asynchronously on its assertion, the block SHALL force the following, including mid-burst:
- state = IDLE, busy = 0, done = 0;
- m_valid = 0, m_last = 0, m_data = 0, ram_addr = 0;
- FIFO count = 0, in-flight pipeline cleared, remaining count = 0.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge of clk.

Verification
REQ-031 The bench SHALL cover the following directed scenarios, with the BRAM preloaded so that mem[i] = i+0x10.
- Scenario 1: start_addr=3, length=4, m_ready=1 -> m_data 0x13,0x14,0x15,0x16 on 4 consecutive cycles starting 2 cycles after start, m_last on 0x16, done pulse the cycle after.
- Scenario 2: start_addr=14, length=4 (RAM_ADDR_WIDTH=4) -> beats 0x1E,0x1F,0x10,0x11 (address wrap 15 -> 0).
- Scenario 3: length=4, m_ready low for 5 cycles after start, then high -> 3 entries buffered, no reads issued while the FIFO is full, all 4 beats in order, m_data stable while stalled.
- Scenario 4: length=0 -> busy high 1 cycle, done pulses 1 cycle after start, m_valid never asserted.
- Scenario 5: rst asserted after 2 beats of a length=8 burst -> all outputs 0 immediately; a new start (start_addr=0, length=2) then yields 0x10,0x11 with no stale data.
- Scenario 6: random m_ready, length=16 -> 16 beats, addresses 0..15 each exactly once in order; start pulses issued during the burst are ignored.
